// File: rtl/calc_sseg_scan_ctrl.sv
// calc_sseg_scan_ctrl
//   Captures an 8-bit calculator result plus overflow flag on a load strobe,
//   converts it to three BCD digits with a one-shift-per-clock double-dabble
//   engine, and time-multiplexes the digits onto an 8-anode display.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   load      capture strobe, honoured only while idle
//   rslt[7:0] unsigned result to display
//   overf     overflow flag shown on the ones-digit decimal point
//   busy      high while a conversion is running
//   num[3:0]  BCD value of the currently scanned digit
//   an[7:0]   active-low anode selects (an[7:3] always 1)
//   dp        active-low decimal point of the scanned digit
//
// Parameter: REFRESH_DIV  cycles each digit stays lit (>= 2)
// Option:    CALC_LEAD_ZERO_BLANK_EN  blanks leading-zero hundreds/tens slots
module calc_sseg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] rslt,
    input  logic       overf,
    output logic       busy,
    output logic [3:0] num,
    output logic [7:0] an,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t      state_q;
    logic        busy_q;
    logic [19:0] sh_q, sh_d;    // {hund, tens, ones, binary}
    logic [19:0] adj;
    logic [2:0]  cnt_q;
    logic        ovf_q;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic        ovf_disp_q;
    logic [PW-1:0] pre_q;
    logic [1:0]  idx_q;

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift.
    always_comb begin
        adj = sh_q;
        for (int i = 0; i < 3; i++) begin
            if (sh_q[8+4*i +: 4] >= 4'd5)
                adj[8+4*i +: 4] = sh_q[8+4*i +: 4] + 4'd3;
        end
        sh_d = adj << 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            hund_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            ovf_disp_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        sh_q    <= {12'b0, rslt};
                        ovf_q   <= overf;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                default: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 3'd1;
                    // Eighth shift: commit the whole result at once so the
                    // scan never shows a partially converted value.
                    if (cnt_q == 3'd7) begin
                        hund_q     <= sh_d[19:16];
                        tens_q     <= sh_d[15:12];
                        ones_q     <= sh_d[11:8];
                        ovf_disp_q <= ovf_q;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Refresh scan: free-running, independent of conversion activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_q <= '0;
            case (idx_q)
                2'd0:    idx_q <= 2'd1;
                2'd1:    idx_q <= 2'd2;
                default: idx_q <= 2'd0;   // also recovers from index 3
            endcase
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_comb begin
        an  = 8'hFE;
        num = ones_q;
        dp  = 1'b1;
        case (idx_q)
            2'd0: begin
                an  = 8'hFE;
                num = ones_q;
                dp  = ~ovf_disp_q;
            end
            2'd1: begin
                an  = 8'hFD;
                num = tens_q;
`ifdef CALC_LEAD_ZERO_BLANK_EN
                if (hund_q == 4'd0 && tens_q == 4'd0) an = 8'hFF;
`endif
            end
            2'd2: begin
                an  = 8'hFB;
                num = hund_q;
`ifdef CALC_LEAD_ZERO_BLANK_EN
                if (hund_q == 4'd0) an = 8'hFF;
`endif
            end
            default: begin
                an  = 8'hFE;
                num = ones_q;
                dp  = ~ovf_disp_q;
            end
        endcase
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_calc_sseg_scan_ctrl.sv
module tb_calc_sseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] rslt = '0;
    logic       overf = 1'b0;
    logic       busy;
    logic [3:0] num;
    logic [7:0] an;
    logic       dp;

    int errs = 0;
    int n_chk = 0;

    calc_sseg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .rslt(rslt), .overf(overf),
        .busy(busy), .num(num), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard of accepted loads: {overf, rslt}
    logic [8:0] sb[$];
    logic [7:0] disp_exp = '0;
    logic       ovf_exp = 1'b0;
    int         bcnt = 0;
    logic       prev_busy = 1'b0;
    bit         mon_en = 1'b0;

    // Cycles since reset release; slot index follows from it.
    int m_cyc = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_cyc <= 0;
        else          m_cyc <= m_cyc + 1;
    end

    always @(negedge clk) begin
        int        idx;
        logic [3:0] d [3];
        logic [7:0] e_an;
        logic [3:0] e_num;
        logic       e_dp;
        logic [8:0] ent;
        if (!reset_n) begin
            disp_exp  = '0;
            ovf_exp   = 1'b0;
            bcnt      = 0;
            prev_busy = 1'b0;
            sb.delete();
        end else if (mon_en) begin
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                chk("busy_len", bcnt, 8);
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    ent = sb.pop_front();
                    disp_exp = ent[7:0];
                    ovf_exp  = ent[8];
                end
                bcnt = 0;
            end
            prev_busy = busy;

            d[0] = 4'(disp_exp % 10);
            d[1] = 4'((disp_exp / 10) % 10);
            d[2] = 4'(disp_exp / 100);
            idx = (m_cyc / 4) % 3;
            e_num = d[idx];
            e_dp  = (idx == 0) ? ~ovf_exp : 1'b1;
            case (idx)
                0: e_an = 8'hFE;
                1: e_an = 8'hFD;
                default: e_an = 8'hFB;
            endcase
`ifdef CALC_LEAD_ZERO_BLANK_EN
            if (idx == 2 && d[2] == 0) e_an = 8'hFF;
            if (idx == 1 && d[2] == 0 && d[1] == 0) e_an = 8'hFF;
`endif
            chk("an", an, e_an);
            chk("num", num, e_num);
            chk("dp", dp, e_dp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load over one rising edge; push when the caller expects acceptance.
    task automatic do_load(input logic [7:0] v, input logic o, input bit accept);
        rslt  = v;
        overf = o;
        load  = 1'b1;
        if (accept) sb.push_back({o, v});
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_an", an, 8'hFE);
        chk("rst_num", num, 0);
        chk("rst_dp", dp, 1);
        run(2);
        #3 reset_n = 1'b1;
        mon_en = 1'b1;
        run(14);

        do_load(8'd255, 1'b0, 1);
        wait_idle();
        run(14);

        do_load(8'd7, 1'b0, 1);
        wait_idle();
        run(14);

        do_load(8'd100, 1'b1, 1);
        wait_idle();
        run(14);
        do_load(8'd100, 1'b0, 1);
        wait_idle();
        run(14);

        // Load during conversion is dropped.
        do_load(8'd200, 1'b0, 1);
        run(2);
        do_load(8'd9, 1'b0, 0);
        wait_idle();
        run(14);

        // Load coinciding with the final conversion edge is dropped.
        do_load(8'd37, 1'b1, 1);
        run(7);
        do_load(8'd99, 1'b0, 0);
        run(3);
        chk("t8_busy", busy, 0);
        run(12);

        // Reset in the middle of a conversion.
        do_load(8'd255, 1'b0, 1);
        wait_idle();
        run(4);
        do_load(8'd42, 1'b1, 0);
        run(3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_an", an, 8'hFE);
        chk("mid_rst_num", num, 0);
        chk("mid_rst_dp", dp, 1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        run(14);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
